// File: rtl/mdu_issue_ctrl.sv
// Issue/interlock controller for the multiply/divide unit: start pulse, shadow busy, D-stage stall.
// Optional build macro MDU_DIV0_SKIP_EN: a zero-divisor div/divu issues but never enters DIV_RUN.
module mdu_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDUOp,
    input  logic [31:0] E_B,
    input  logic        E_flush,
    input  logic        D_uses_md,
    input  logic        mdu_busy,
    output logic        start,
    output logic [2:0]  MDUOp,
    output logic        busy_o,
    output logic        md_stall,
    output logic [31:0] stall_cnt,
    output logic        sync_err,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic [31:0] stall_cnt_q;
    logic        sync_err_q;

    logic is_mult;
    logic is_div;
    logic div_skip;

    assign is_mult = (E_MDUOp == 3'd1) || (E_MDUOp == 3'd2);
    assign is_div  = (E_MDUOp == 3'd3) || (E_MDUOp == 3'd4);

`ifdef MDU_DIV0_SKIP_EN
    assign div_skip = is_div && (E_B == 32'd0);
`else
    logic unused_e_b;
    assign unused_e_b = ^E_B;
    assign div_skip   = 1'b0;
`endif

    // start is a one-cycle pulse with no return handshake: the MDU must accept
    // it unconditionally; a new op is only offered while the shadow busy is low.
    assign start    = (is_mult || is_div) && !E_flush && !busy_q;
    assign MDUOp    = (E_flush || (E_MDUOp == 3'd7)) ? 3'd0 : E_MDUOp;
    assign md_stall = D_uses_md && (start || busy_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            busy_q      <= 1'b0;
            stall_cnt_q <= 32'd0;
            sync_err_q  <= 1'b0;
        end else begin
            if (md_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (mdu_busy != busy_q) begin
                sync_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start && !div_skip) begin
                        busy_q <= 1'b1;
                        if (is_mult) begin
                            state_q <= MULT_RUN;
                            cnt_q   <= 5'(MULT_CYCLES);
                        end else begin
                            state_q <= DIV_RUN;
                            cnt_q   <= 5'(DIV_CYCLES);
                        end
                    end
                end
                MULT_RUN, DIV_RUN: begin
                    if (cnt_q == 5'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 5'd0;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 5'd0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign stall_cnt   = stall_cnt_q;
    assign sync_err    = sync_err_q;
    assign state_dbg_o = state_q;

endmodule
